pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed-width M→W register.
- Carries Instr, PC, RFWA, branch-delay flag and a wide generic payload bus (ALUout/HI/LO/DMRD/CP0RD concatenated by the instantiating stage).
- Adds a valid bit, stall hold, bubble gating and parametrised reset/flush PC values.
- Instantiated between every adjacent pair of stages (D/E, E/M, M/W); interrupt/exception flush inputs keep their codebase names.

Parameters:
- PAYLOAD_W, 160, width of generic payload bus (5 × 32 for M→W).
- RESET_PC, 32'h00003000, PC_o value after reset.
- FLUSH_PC, 32'h00000000, PC_o value after interrupt/exception flush.
- CNT_W, 32, width of performance counters (used only with PIPE_PERF_CNT_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- IntReq  in  1  interrupt flush request.
- ExcReq  in  1  exception flush request.
- stall  in  1  hold all stage contents.
- valid_i  in  1  upstream holds a real instruction.
- Instr_i  in  32  instruction word.
- PC_i  in  32  instruction PC.
- RFWA_i  in  5  register-file write address.
- bd_i  in  1  instruction is in a branch delay slot.
- payload_i  in  PAYLOAD_W  stage data.
- valid_o  out  1  registered valid.
- Instr_o  out  32  registered instruction.
- PC_o  out  32  registered PC.
- RFWA_o  out  5  registered write address.
- bd_o  out  1  registered delay-slot flag.
- payload_o  out  PAYLOAD_W  registered payload.
- retire_cnt  out  CNT_W  loads of valid instructions.
- bubble_cnt  out  CNT_W  bubbles inserted (invalid load or flush).
- stall_cnt  out  CNT_W  cycles spent holding.

Behaviour:
- Single clock domain; all outputs registered; latency is 1 cycle from input to output.
- reset is synchronous and active-high; clk and reset are named as in the codebase.
- Per rising edge, priority is reset > flush (IntReq|ExcReq) > stall > load.
- Reset: valid_o=0, Instr_o=0, PC_o=RESET_PC, RFWA_o=0, bd_o=0, payload_o=0; counters=0.
- Flush (IntReq or ExcReq, or both): valid_o=0, Instr_o=0, PC_o=FLUSH_PC, RFWA_o=0, bd_o=0, payload_o=0. Flush overrides a simultaneous stall.
- Stall (no reset, no flush): every output holds its previous value.
- Load, valid_i=1: all outputs take their _i values; valid_o=1.
- Load, valid_i=0 (bubble gating):
  - valid_o=0, Instr_o=0, RFWA_o=0, bd_o=0, payload_o=0.
  - PC_o=PC_i, so the bubble retains the PC for EPC reporting.
- RFWA_o is guaranteed 0 whenever valid_o=0, so no spurious write-back or forwarding match is possible.
- Reset asserted mid-stall: reset wins on that edge. Stall is ignored while reset or flush is high.
- No combinational path from any input to any output.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: three saturating counters, each cleared by reset and never incremented on a reset edge.
  - retire_cnt: +1 on a load edge with valid_i=1.
  - bubble_cnt: +1 on a load edge with valid_i=0, or on any flush edge.
  - stall_cnt: +1 on a stall-hold edge.
  - Each counter holds at all-ones (2^CNT_W−1) instead of wrapping.
- Undefined: the counter ports remain present, are driven constant 0, and no counter flops are synthesised.

Test Plan:
1. Reset for 2 cycles, then release → PC_o=32'h00003000, all other outputs 0, counters 0.
2. valid_i=1, Instr_i=32'h8C410004, PC_i=32'h00003010, RFWA_i=1, payload_i=all 5s, stall=0 → next cycle outputs equal the inputs, valid_o=1; retire_cnt=1 (with macro).
3. stall=1 for 3 cycles while inputs change to PC_i=32'h00003014 → outputs frozen at the scenario-2 values; stall_cnt=3.
4. stall=1 and ExcReq=1 on the same edge → valid_o=0, PC_o=32'h00000000, RFWA_o=0, payload_o=0; bubble_cnt +1, stall_cnt unchanged.
5. valid_i=0, PC_i=32'h00003020, RFWA_i=31, Instr_i=32'hFFFFFFFF → valid_o=0, RFWA_o=0, Instr_o=0, PC_o=32'h00003020.
6. With CNT_W=4, 20 consecutive valid loads → retire_cnt saturates at 15. Rebuild without PIPE_PERF_CNT_EN → all counters read 0 throughout.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid, stall hold, bubble gating and flush.
// Optional saturating performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_reg #(
  parameter int          PAYLOAD_W = 160,
  parameter logic [31:0] RESET_PC  = 32'h00003000,
  parameter logic [31:0] FLUSH_PC  = 32'h00000000,
  parameter int          CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 IntReq,
  input  logic                 ExcReq,
  input  logic                 stall,
  input  logic                 valid_i,
  input  logic [31:0]          Instr_i,
  input  logic [31:0]          PC_i,
  input  logic [4:0]           RFWA_i,
  input  logic                 bd_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 valid_o,
  output logic [31:0]          Instr_o,
  output logic [31:0]          PC_o,
  output logic [4:0]           RFWA_o,
  output logic                 bd_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);
  logic                 flush, load;
  logic                 valid_q, valid_d, bd_q, bd_d;
  logic [31:0]          instr_q, instr_d, pc_q, pc_d;
  logic [4:0]           rfwa_q, rfwa_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  assign flush = IntReq | ExcReq;
  assign load  = !flush && !stall;
  // Bubbles keep PC_i for EPC reporting but zero everything else, so RFWA never matches when invalid.
  always_comb begin
    valid_d   = flush ? 1'b0 : stall ? valid_q : valid_i;
    instr_d   = flush ? '0 : stall ? instr_q : valid_i ? Instr_i : '0;
    pc_d      = flush ? FLUSH_PC : stall ? pc_q : PC_i;
    rfwa_d    = flush ? '0 : stall ? rfwa_q : valid_i ? RFWA_i : '0;
    bd_d      = flush ? 1'b0 : stall ? bd_q : valid_i & bd_i;
    payload_d = flush ? '0 : stall ? payload_q : valid_i ? payload_i : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_q      <= RESET_PC;
      rfwa_q    <= '0;
      bd_q      <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      rfwa_q    <= rfwa_d;
      bd_q      <= bd_d;
      payload_q <= payload_d;
    end
  end
  assign valid_o   = valid_q;
  assign Instr_o   = instr_q;
  assign PC_o      = pc_q;
  assign RFWA_o    = rfwa_q;
  assign bd_o      = bd_q;
  assign payload_o = payload_q;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] retire_q, retire_d, bubble_q, bubble_d, stall_q, stall_d;
  always_comb begin
    retire_d = (load && valid_i && ~&retire_q) ? retire_q + CNT_W'(1) : retire_q;
    bubble_d = ((flush || (load && !valid_i)) && ~&bubble_q) ? bubble_q + CNT_W'(1) : bubble_q;
    stall_d  = (!flush && stall && ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_q <= '0;
      bubble_q <= '0;
      stall_q  <= '0;
    end else begin
      retire_q <= retire_d;
      bubble_q <= bubble_d;
      stall_q  <= stall_d;
    end
  end
  assign retire_cnt = retire_q;
  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;
`else
  assign retire_cnt = '0;
  assign bubble_cnt = '0;
  assign stall_cnt  = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vectors, expected responses queued and checked by a separate monitor.
module tb_pipe_stage_reg;
  localparam int PW = 160;
  localparam int CW = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1, IntReq = 1'b0, ExcReq = 1'b0, stall = 1'b0, valid_i = 1'b0, bd_i = 1'b0;
  logic [31:0] Instr_i = '0, PC_i = '0;
  logic [4:0] RFWA_i = '0;
  logic [PW-1:0] payload_i = '0;
  logic valid_o, bd_o;
  logic [31:0] Instr_o, PC_o;
  logic [4:0] RFWA_o;
  logic [PW-1:0] payload_o;
  logic [CW-1:0] retire_cnt, bubble_cnt, stall_cnt;

  pipe_stage_reg #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .IntReq(IntReq), .ExcReq(ExcReq), .stall(stall),
    .valid_i(valid_i), .Instr_i(Instr_i), .PC_i(PC_i), .RFWA_i(RFWA_i), .bd_i(bd_i),
    .payload_i(payload_i), .valid_o(valid_o), .Instr_o(Instr_o), .PC_o(PC_o),
    .RFWA_o(RFWA_o), .bd_o(bd_o), .payload_o(payload_o), .retire_cnt(retire_cnt),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    string         name;
    logic          v;
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [4:0]    rfwa;
    logic          bd;
    logic [PW-1:0] pl;
    logic [CW-1:0] ret;
    logic [CW-1:0] bub;
    logic [CW-1:0] stl;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int applied = 0;
  int miscompares = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      applied++;
      if (valid_o !== e.v || Instr_o !== e.instr || PC_o !== e.pc || RFWA_o !== e.rfwa ||
          bd_o !== e.bd || payload_o !== e.pl || retire_cnt !== e.ret ||
          bubble_cnt !== e.bub || stall_cnt !== e.stl) begin
        miscompares++;
        $display("FAIL %s: got v=%b i=%h pc=%h ra=%0d bd=%b pl=%h cnt=%0d/%0d/%0d want v=%b i=%h pc=%h ra=%0d bd=%b pl=%h cnt=%0d/%0d/%0d",
          e.name, valid_o, Instr_o, PC_o, RFWA_o, bd_o, payload_o, retire_cnt, bubble_cnt, stall_cnt,
          e.v, e.instr, e.pc, e.rfwa, e.bd, e.pl, e.ret, e.bub, e.stl);
      end
    end
  end

  task automatic step(input string name, input logic r, input logic irq, input logic exc,
                      input logic stl, input logic vi, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [4:0] ra, input logic bd, input logic [PW-1:0] pl,
                      input logic ev, input logic [31:0] eins, input logic [31:0] epc,
                      input logic [4:0] era, input logic ebd, input logic [PW-1:0] epl,
                      input int eret, input int ebub, input int estl);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; IntReq = irq; ExcReq = exc; stall = stl; valid_i = vi;
    Instr_i = ins; PC_i = pc; RFWA_i = ra; bd_i = bd; payload_i = pl;
    e.due = cyc + 1; e.name = name; e.v = ev; e.instr = eins; e.pc = epc; e.rfwa = era;
    e.bd = ebd; e.pl = epl;
    e.ret = PERF ? CW'(eret) : '0;
    e.bub = PERF ? CW'(ebub) : '0;
    e.stl = PERF ? CW'(estl) : '0;
    sb.push_back(e);
  endtask

  logic [PW-1:0] p5, pa, pc3;
  initial begin
    p5  = {40{4'h5}};
    pa  = {40{4'hA}};
    pc3 = {5{32'hC0DE0003}};
    step("reset1", 1,0,0,0, 1,32'h12345678,32'h00001234,5'd9,1,pa, 0,0,32'h00003000,0,0,'0, 0,0,0);
    step("reset2", 1,0,0,1, 1,32'h12345678,32'h00001234,5'd9,1,pa, 0,0,32'h00003000,0,0,'0, 0,0,0);
    step("load",   0,0,0,0, 1,32'h8C410004,32'h00003010,5'd1,0,p5, 1,32'h8C410004,32'h00003010,5'd1,0,p5, 1,0,0);
    for (int i = 1; i <= 3; i++)
      step("stall", 0,0,0,1, 1,32'h11111111,32'h00003014,5'd2,1,pa, 1,32'h8C410004,32'h00003010,5'd1,0,p5, 1,0,i);
    step("exc_over_stall", 0,0,1,1, 1,32'h22222222,32'h00003018,5'd3,0,pa, 0,0,32'h00000000,0,0,'0, 1,1,3);
    step("bubble", 0,0,0,0, 0,32'hFFFFFFFF,32'h00003020,5'd31,1,pa, 0,0,32'h00003020,0,0,'0, 1,2,3);
    step("int_flush", 0,1,0,0, 1,32'h33333333,32'h00003024,5'd4,0,pa, 0,0,32'h00000000,0,0,'0, 1,3,3);
    step("both_flush", 0,1,1,0, 1,32'h33333333,32'h00003024,5'd4,0,pa, 0,0,32'h00000000,0,0,'0, 1,4,3);
    step("load_bd", 0,0,0,0, 1,32'h00000001,32'h00003028,5'd7,1,pc3, 1,32'h00000001,32'h00003028,5'd7,1,pc3, 2,4,3);
    step("stall2", 0,0,0,1, 0,32'h0,32'h0000302C,5'd8,0,pa, 1,32'h00000001,32'h00003028,5'd7,1,pc3, 2,4,4);
    step("reset_in_stall", 1,0,0,1, 1,32'h44444444,32'h00003030,5'd9,1,pa, 0,0,32'h00003000,0,0,'0, 0,0,0);
    for (int i = 0; i < 20; i++)
      step("sat_load", 0,0,0,0, 1,32'(i),32'h00003000 + 32'(4*i),5'(i),0,p5,
           1,32'(i),32'h00003000 + 32'(4*i),5'(i),0,p5, (i+1 > 15) ? 15 : i+1,0,0);
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never checked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
